// File: rtl/booth4_mult_param.sv
// Multicycle radix-4 Booth multiplier: one Booth digit per clock, full 2*WIDTH product,
// ready pulse and overflow exception. Define MULT_DIAG_EN to expose dbg_acc / dbg_booth.
module booth4_mult_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ctrl_MULT,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi,
  output logic             data_resultRDY,
  output logic             data_exception,
  output logic             busy
`ifdef MULT_DIAG_EN
  ,
  output logic [2*WIDTH+5:0] dbg_acc,
  output logic [2:0]         dbg_booth
`endif
);

  localparam int ITERS = WIDTH / 2 + 1;
  localparam int EW    = WIDTH + 2;
  localparam int PW    = 2 * WIDTH + 5;
  localparam int CW    = $clog2(ITERS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   count_r;
  logic [EW-1:0]   opa_r;
  logic [PW-1:0]   acc_r;
  logic            unsigned_r;

  logic [EW-1:0]      mag_s;
  logic [EW-1:0]      addend_s;
  logic [EW-1:0]      sum_s;
  logic               neg_s;
  logic [PW-1:0]      step_s;
  logic [PW-1:0]      start_acc_s;
  logic [EW-1:0]      start_opa_s;
  logic [2*WIDTH-1:0] prod_s;

  function automatic logic [EW-1:0] ext_op(input logic [WIDTH-1:0] v, input logic uns);
    ext_op = {{2{~uns & v[WIDTH-1]}}, v};
  endfunction

  function automatic logic ovf_check(input logic [2*WIDTH-1:0] prod, input logic uns);
    logic [WIDTH:0] top;
    top = prod[2*WIDTH-1:WIDTH-1];
    if (uns) begin
      ovf_check = (prod[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
    end else begin
      ovf_check = !((top == {(WIDTH+1){1'b0}}) || (top == {(WIDTH+1){1'b1}}));
    end
  endfunction

  // Booth digit decode, add/subtract on the upper accumulator half, then 2-bit arithmetic shift
  always_comb begin
    mag_s = {EW{1'b0}};
    neg_s = 1'b0;
    case (acc_r[2:0])
      3'b001, 3'b010: mag_s = opa_r;
      3'b011:         mag_s = {opa_r[EW-2:0], 1'b0};
      3'b100: begin
        mag_s = {opa_r[EW-2:0], 1'b0};
        neg_s = 1'b1;
      end
      3'b101, 3'b110: begin
        mag_s = opa_r;
        neg_s = 1'b1;
      end
      default: begin
        mag_s = {EW{1'b0}};
        neg_s = 1'b0;
      end
    endcase
    addend_s    = neg_s ? ~mag_s : mag_s;
    sum_s       = acc_r[PW-1:EW+1] + addend_s + {{(EW-1){1'b0}}, neg_s};
    step_s      = {{2{sum_s[EW-1]}}, sum_s, acc_r[EW:2]};
    start_opa_s = ext_op(data_operandA, is_unsigned);
    start_acc_s = {{EW{1'b0}}, ext_op(data_operandB, is_unsigned), 1'b0};
    prod_s      = acc_r[2*WIDTH:1];
  end

  // Control FSM with datapath registers and registered outputs
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r        <= ST_IDLE;
      count_r        <= {CW{1'b0}};
      opa_r          <= {EW{1'b0}};
      acc_r          <= {PW{1'b0}};
      unsigned_r     <= 1'b0;
      product_lo     <= {WIDTH{1'b0}};
      product_hi     <= {WIDTH{1'b0}};
      data_resultRDY <= 1'b0;
      data_exception <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          data_resultRDY <= 1'b0;
          if (ctrl_MULT) begin
            opa_r      <= start_opa_s;
            acc_r      <= start_acc_s;
            unsigned_r <= is_unsigned;
            count_r    <= {CW{1'b0}};
            busy       <= 1'b1;
            state_r    <= ST_RUN;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_RUN: begin
          data_resultRDY <= 1'b0;
          if (ctrl_MULT) begin
            // restart: the operation in flight is abandoned
            opa_r      <= start_opa_s;
            acc_r      <= start_acc_s;
            unsigned_r <= is_unsigned;
            count_r    <= {CW{1'b0}};
            busy       <= 1'b1;
          end else begin
            acc_r   <= step_s;
            count_r <= count_r + CW'(1);
            if (count_r == CW'(ITERS - 1)) begin
              busy    <= 1'b0;
              state_r <= ST_DONE;
            end else begin
              busy <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          data_resultRDY <= 1'b1;
          product_lo     <= prod_s[WIDTH-1:0];
          product_hi     <= prod_s[2*WIDTH-1:WIDTH];
          data_exception <= ovf_check(prod_s, unsigned_r);
          if (ctrl_MULT) begin
            opa_r      <= start_opa_s;
            acc_r      <= start_acc_s;
            unsigned_r <= is_unsigned;
            count_r    <= {CW{1'b0}};
            busy       <= 1'b1;
            state_r    <= ST_RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          data_resultRDY <= 1'b0;
          busy           <= 1'b0;
          state_r        <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MULT_DIAG_EN
  assign dbg_acc   = {1'b0, acc_r};
  assign dbg_booth = acc_r[2:0];
`endif

endmodule

// File: tb/tb_booth4_mult_param.sv
// Scoreboard bench for booth4_mult_param at WIDTH=32 and WIDTH=8, against plain-arithmetic products.
module tb_booth4_mult_param;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        c32, u32, rdy32, exc32, busy32;
  logic [31:0] a32, b32, lo32, hi32;
  logic        c8, u8, rdy8, exc8, busy8;
  logic [7:0]  a8, b8, lo8, hi8;
`ifdef MULT_DIAG_EN
  logic [69:0] dacc32;
  logic [2:0]  dbth32;
  logic [21:0] dacc8;
  logic [2:0]  dbth8;
`endif

  booth4_mult_param #(.WIDTH(32)) u_dut32 (
    .clk(clk), .clr_n(clr_n), .ctrl_MULT(c32), .is_unsigned(u32),
    .data_operandA(a32), .data_operandB(b32), .product_lo(lo32), .product_hi(hi32),
    .data_resultRDY(rdy32), .data_exception(exc32), .busy(busy32)
`ifdef MULT_DIAG_EN
    , .dbg_acc(dacc32), .dbg_booth(dbth32)
`endif
  );

  booth4_mult_param #(.WIDTH(8)) u_dut8 (
    .clk(clk), .clr_n(clr_n), .ctrl_MULT(c8), .is_unsigned(u8),
    .data_operandA(a8), .data_operandB(b8), .product_lo(lo8), .product_hi(hi8),
    .data_resultRDY(rdy8), .data_exception(exc8), .busy(busy8)
`ifdef MULT_DIAG_EN
    , .dbg_acc(dacc8), .dbg_booth(dbth8)
`endif
  );

  typedef struct {
    logic [63:0] p;
    logic        exc;
    int          issue;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b, input logic uns);
    exp_t        m;
    longint      sp;
    logic [63:0] up;
    if (uns) begin
      up    = {32'd0, a} * {32'd0, b};
      m.p   = up;
      m.exc = (up > 64'h0000_0000_FFFF_FFFF);
    end else begin
      sp    = longint'($signed(a)) * longint'($signed(b));
      m.p   = sp;
      m.exc = (sp < -64'sd2147483648) || (sp > 64'sd2147483647);
    end
    m.issue = 0;
    return m;
  endfunction

  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic uns);
    exp_t m;
    int   p;
    if (uns) begin
      p     = int'(a) * int'(b);
      m.exc = (p > 255);
    end else begin
      p     = int'($signed(a)) * int'($signed(b));
      m.exc = (p < -128) || (p > 127);
    end
    m.p     = {48'd0, p[15:0]};
    m.issue = 0;
    return m;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Called at a negedge; the following posedge samples the operation.
  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic uns);
    exp_t e;
    e       = model32(a, b, uns);
    e.issue = cyc + 1;
    q32.push_back(e);
    a32 = a; b32 = b; u32 = uns; c32 = 1'b1;
    @(negedge clk);
    c32 = 1'b0; a32 = $urandom(); b32 = $urandom(); u32 = 1'($urandom());
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic uns);
    exp_t e;
    e       = model8(a, b, uns);
    e.issue = cyc + 1;
    q8.push_back(e);
    a8 = a; b8 = b; u8 = uns; c8 = 1'b1;
    @(negedge clk);
    c8 = 1'b0; a8 = 8'($urandom()); b8 = 8'($urandom()); u8 = 1'($urandom());
  endtask

  task automatic drain32();
    for (int i = 0; i < 200 && q32.size() != 0; i++) @(negedge clk);
    if (q32.size() != 0) begin
      check("timeout32", 64'(q32.size()), 64'd0);
      q32.delete();
    end
  endtask

  task automatic drain8();
    for (int i = 0; i < 100 && q8.size() != 0; i++) @(negedge clk);
    if (q8.size() != 0) begin
      check("timeout8", 64'(q8.size()), 64'd0);
      q8.delete();
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding operation
  always @(negedge clk) begin : mon32
    exp_t e;
    if (clr_n && rdy32) begin
      if (q32.size() == 0) begin
        check("rdy32_unexpected", 64'd1, 64'd0);
      end else begin
        e = q32.pop_front();
        check("prod32", {hi32, lo32}, e.p);
        check("exc32", 64'(exc32), 64'(e.exc));
        check("lat32", 64'(cyc - e.issue), 64'd18);
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (clr_n && rdy8) begin
      if (q8.size() == 0) begin
        check("rdy8_unexpected", 64'd1, 64'd0);
      end else begin
        e = q8.pop_front();
        check("prod8", {48'd0, hi8, lo8}, e.p);
        check("exc8", 64'(exc8), 64'(e.exc));
        check("lat8", 64'(cyc - e.issue), 64'd6);
      end
    end
  end

  initial begin
    int iss;
    clr_n = 1'b0;
    c32 = 1'b0; u32 = 1'b0; a32 = 32'd0; b32 = 32'd0;
    c8  = 1'b0; u8  = 1'b0; a8  = 8'd0;  b8  = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_prod32", {hi32, lo32}, 64'd0);
    check("rst_flags32", {61'd0, rdy32, exc32, busy32}, 64'd0);
    check("rst_prod8", {48'd0, hi8, lo8}, 64'd0);
    check("rst_flags8", {61'd0, rdy8, exc8, busy8}, 64'd0);
`ifdef MULT_DIAG_EN
    check("rst_dbg32", dacc32[63:0], 64'd0);
    check("rst_dbgb32", 64'(dbth32), 64'd0);
    check("rst_dbg8", 64'(dacc8), 64'd0);
`endif
    clr_n = 1'b1;
    @(negedge clk);

    issue32(32'd7, 32'hFFFF_FFFD, 1'b0);
    repeat (3) @(negedge clk);
    check("busy32_run", 64'(busy32), 64'd1);
    drain32();
    check("busy32_idle", 64'(busy32), 64'd0);

    issue32(32'h8000_0000, 32'h8000_0000, 1'b0); drain32();
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); drain32();
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); drain32();

    // Restart while running: the first operation must never report
    issue32(32'd5, 32'd6, 1'b0);
    iss = q32[q32.size()-1].issue;
    while (cyc < iss + 7) @(negedge clk);
    void'(q32.pop_back());
    issue32(32'd9, 32'd9, 1'b0);
    drain32();

    // New start sampled in the finishing cycle: both operations report
    issue32(32'd1234, 32'hFFFF_0000, 1'b0);
    iss = q32[q32.size()-1].issue;
    while (cyc < iss + 17) @(negedge clk);
    issue32(32'hDEAD_BEEF, 32'h0000_1001, 1'b1);
    drain32();

    // Asynchronous reset mid-operation
    issue32(32'd12345, 32'd678, 1'b0);
    repeat (5) @(negedge clk);
    clr_n = 1'b0;
    #1;
    check("arst_prod32", {hi32, lo32}, 64'd0);
    check("arst_flags32", {61'd0, rdy32, exc32, busy32}, 64'd0);
    q32.delete();
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    issue32(32'd2, 32'd3, 1'b0);
    drain32();

    for (int i = 0; i < 40; i++) begin
      issue32(pick32(), pick32(), 1'($urandom()));
      drain32();
    end

    issue8(8'h80, 8'h7F, 1'b0);
    drain8();
    issue8(8'hFF, 8'hFF, 1'b1); drain8();
    issue8(8'h80, 8'h80, 1'b0); drain8();
    for (int i = 0; i < 60; i++) begin
      issue8(8'($urandom()), 8'($urandom()), 1'($urandom()));
      drain8();
    end

    repeat (40) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
